// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: queued scancode bytes are sent as
// 11-bit frames (start, 8 data LSB first, odd parity, stop) with an idle gap.
//
// state  | meaning
// IDLE   | clk=1, data=1, pops the next byte when the FIFO is non-empty
// HIGH   | clk=1, data holds the current frame bit for HALF cycles
// LOW    | clk=0, data unchanged for HALF cycles (receiver samples here)
// GAPW   | clk=1, data=1 for GAP cycles after the stop bit
module ps2_kbd_tx #(
    parameter int unsigned HALF       = 2400,
    parameter int unsigned GAP        = 9600,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_wr,
    output logic       full,
    output logic       overflow,
    output logic       busy,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int unsigned          DEPTH       = 1 << DEPTH_LOG2;
    localparam logic [15:0]          HALF_RELOAD = 16'(HALF - 1);
    localparam logic [15:0]          GAP_RELOAD  = 16'(GAP - 1);
    localparam logic [DEPTH_LOG2:0]  DEPTH_CNT   = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = (DEPTH_LOG2)'(1);
    localparam logic [3:0]           LAST_IDX    = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_GAPW = 2'd3
    } state_t;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q;
    logic [DEPTH_LOG2-1:0] rptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  ovf_q;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        clk_q, clk_d;
    logic        data_q, data_d;
    logic        pop;
    logic        push;

    // Bit i of the frame for byte b: start, data LSB first, odd parity, stop.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] i);
        logic r;
        if (i == 4'd0) begin
            r = 1'b0;
        end else if (i <= 4'd8) begin
            r = b[3'(i - 4'd1)];
        end else if (i == 4'd9) begin
            r = ~^b;
        end else begin
            r = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        clk_d   = clk_q;
        data_d  = data_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                clk_d  = 1'b1;
                data_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rptr_q];
                    idx_d   = 4'd0;
                    cnt_d   = HALF_RELOAD;
                    state_d = S_HIGH;
                    data_d  = 1'b0;
                end
            end
            S_HIGH: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = HALF_RELOAD;
                    state_d = S_LOW;
                    clk_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_LOW: begin
                if (cnt_q == 16'd0) begin
                    clk_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        cnt_d   = GAP_RELOAD;
                        state_d = S_GAPW;
                        data_d  = 1'b1;
                    end else begin
                        // Data moves only together with the rising clock edge.
                        idx_d   = idx_q + 4'd1;
                        cnt_d   = HALF_RELOAD;
                        state_d = S_HIGH;
                        data_d  = frame_bit(shreg_q, idx_q + 4'd1);
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_GAPW: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A full FIFO still accepts a push on the cycle it is popped.
    assign push = din_wr && ((count_q != DEPTH_CNT) || pop);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 4'd0;
            shreg_q <= 8'd0;
            clk_q   <= 1'b1;
            data_q  <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            clk_q   <= clk_d;
            data_q  <= data_d;
            ovf_q   <= din_wr && !push;
            if (push) begin
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset && push) begin
            mem_q[wptr_q] <= din;
        end
    end

    assign full     = (count_q == DEPTH_CNT);
    assign busy     = (count_q != '0) || (state_q != S_IDLE);
    assign overflow = ovf_q;
    assign ps2_clk  = clk_q;
    assign ps2_data = data_q;

endmodule
